// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM master/slave bundle used by each port of onchip_mem_arbiter.
// The master modport is the requester side, the slave modport is the arbiter side.
interface onchip_mem_arbiter_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [BE_W-1:0]   byteenable;
   logic [DATA_W-1:0] writedata;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output address, read, write, byteenable, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, byteenable, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter in front of a single-port on-chip RAM (8192 x 32 by default).
// Commands are accepted one at a time: IDLE arbitrates, ISSUE drives the RAM and
// accepts the command, RESP captures the registered RAM output for a read.
// Optional macro ONCHIP_MEM_ARB_FIXED_PRIO_EN: m0 always wins a tie (m1 may starve);
// without it ties are broken round-robin using last_grant.
module onchip_mem_arbiter #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   onchip_mem_arbiter_if.slave   m0,
   onchip_mem_arbiter_if.slave   m1,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_W-1:0]     mem_writedata,
   output logic                  mem_clken,
   input  logic [DATA_W-1:0]     mem_readdata
);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t            state, state_nxt;
   logic              grant, grant_nxt, grant_take;
   logic              last_grant;
   logic              req0, req1;
   logic              g_read, g_write;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic              rvalid0, rvalid1;

   assign req0    = m0.read | m0.write;
   assign req1    = m1.read | m1.write;
   assign g_read  = grant ? m1.read  : m0.read;
   assign g_write = grant ? m1.write : m0.write;

   // Address/data always follow the granted master; only chipselect qualifies them.
   assign mem_address    = grant ? m1.address    : m0.address;
   assign mem_byteenable = grant ? m1.byteenable : m0.byteenable;
   assign mem_writedata  = grant ? m1.writedata  : m0.writedata;
   assign mem_clken      = ~reset;

   assign m0.waitrequest   = ~((state == ISSUE) && !grant);
   assign m1.waitrequest   = ~((state == ISSUE) &&  grant);
   assign m0.readdata      = rdata0;
   assign m1.readdata      = rdata1;
   assign m0.readdatavalid = rvalid0;
   assign m1.readdatavalid = rvalid1;

   // Arbitration, next-state and RAM strobes.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      state_nxt      = state;
      grant_nxt      = grant;
      grant_take     = 1'b0;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
      unique case (state)
         IDLE: begin
            if (req0 || req1) begin
               grant_take = 1'b1;
               state_nxt  = ISSUE;
`ifdef ONCHIP_MEM_ARB_FIXED_PRIO_EN
               grant_nxt  = req0 ? 1'b0 : 1'b1;
`else
               grant_nxt  = (req0 && req1) ? ~last_grant : req1;
`endif
            end
         end
         ISSUE: begin
            mem_chipselect = 1'b1;
            mem_write      = g_write;
            // A write wins over a simultaneous read, so only a pure read waits for data.
            state_nxt      = (g_read && !g_write) ? RESP : IDLE;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, grant and round-robin history registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         state <= state_nxt;
         if (grant_take) begin
            grant      <= grant_nxt;
            last_grant <= grant_nxt;
         end
      end
   end

   // Read-data return: capture RAM output in RESP and pulse valid for one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         rvalid0 <= (state == RESP) && !grant;
         rvalid1 <= (state == RESP) &&  grant;
         if (state == RESP) begin
            if (grant) rdata1 <= mem_readdata;
            else       rdata0 <= mem_readdata;
         end
      end
   end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench for onchip_mem_arbiter with a behavioural RAM and a
// reference memory model; read expectations are queued at accept time and
// compared when readdatavalid arrives.
module tb_onchip_mem_arbiter;
   localparam int ADDR_W = 13;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
   onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteenable;
   logic              mem_chipselect, mem_write, mem_clken;
   logic [DATA_W-1:0] mem_writedata, mem_readdata;

   onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .m0             (m0_if),
      .m1             (m1_if),
      .mem_address    (mem_address),
      .mem_byteenable (mem_byteenable),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_writedata  (mem_writedata),
      .mem_clken      (mem_clken),
      .mem_readdata   (mem_readdata)
   );

   // Behavioural single-port RAM with registered output.
   logic [31:0] ram   [8192];
   logic [31:0] model [8192];
   always @(posedge clk) begin
      if (mem_clken && mem_chipselect) begin
         if (mem_write)
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         mem_readdata <= ram[mem_address];
      end
   end

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int rdv0_cnt = 0;
   int rdv1_cnt = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;
   exp_t sb0[$];
   exp_t sb1[$];
   int   grant_log[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: every readdatavalid must match a queued read, two cycles after accept.
   always @(negedge clk) begin
      exp_t e;
      if (m0_if.readdatavalid) begin
         rdv0_cnt++;
         if (sb0.size() == 0) check("m0_rdv_expected", sb0.size(), 1);
         else begin
            e = sb0.pop_front();
            check("m0_rdata", m0_if.readdata, e.data);
            check("m0_rdv_cycle", cyc, e.cyc + 2);
         end
      end
      if (m1_if.readdatavalid) begin
         rdv1_cnt++;
         if (sb1.size() == 0) check("m1_rdv_expected", sb1.size(), 1);
         else begin
            e = sb1.pop_front();
            check("m1_rdata", m1_if.readdata, e.data);
            check("m1_rdv_cycle", cyc, e.cyc + 2);
         end
      end
   end

   function automatic logic get_wait(input int m);
      return (m == 0) ? m0_if.waitrequest : m1_if.waitrequest;
   endfunction

   task automatic set_cmd(input int m, input logic rd, input logic wr, input logic [12:0] a,
                          input logic [3:0] be, input logic [31:0] d);
      if (m == 0) begin
         m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
         m0_if.byteenable = be; m0_if.writedata = d;
      end else begin
         m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
         m1_if.byteenable = be; m1_if.writedata = d;
      end
   endtask

   // Drive one command (call just after a rising edge); returns the number of
   // cycles the command was presented, counting the accept cycle.
   task automatic do_cmd(input int m, input logic rd, input logic wr, input logic [12:0] a,
                         input logic [3:0] be, input logic [31:0] d, input bit exp_rd,
                         output int n);
      bit   accepted = 0;
      exp_t e;
      set_cmd(m, rd, wr, a, be, d);
      n = 0;
      while (!accepted && n < 200) begin
         @(negedge clk);
         n++;
         if (!get_wait(m)) accepted = 1;
      end
      check("accept", accepted, 1);
      if (accepted) begin
         grant_log.push_back(m);
         check("mem_address", mem_address, a);
         check("mem_write", mem_write, wr);
         if (wr) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
         end else if (rd && exp_rd) begin
            e.data = model[a];
            e.cyc  = cyc;
            if (m == 0) sb0.push_back(e);
            else        sb1.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      set_cmd(m, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic drain(input int k);
      repeat (k) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   // Each master issues a stream of random commands over a small shared address window.
   task automatic stream(input int m, input int count);
      int n;
      logic rd;
      for (int i = 0; i < count; i++) begin
         rd = 1'($urandom_range(0, 1));
         do_cmd(m, rd, ~rd, 13'(32'h40 + $urandom_range(0, 7)), 4'($urandom_range(1, 15)),
                $urandom, 1, n);
`ifndef ONCHIP_MEM_ARB_FIXED_PRIO_EN
         check("stress_wait_le6", n <= 6, 1);
`endif
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, n0, n1, s, c0, c1;
      for (int i = 0; i < 8192; i++) begin
         ram[i]   = 32'hC0DE0000 | i;
         model[i] = 32'hC0DE0000 | i;
      end
      set_cmd(0, 1'b0, 1'b0, '0, '0, '0);
      set_cmd(1, 1'b0, 1'b0, '0, '0, '0);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_m0_wait", m0_if.waitrequest, 1);
      check("rst_m1_wait", m1_if.waitrequest, 1);
      check("rst_m0_rdv", m0_if.readdatavalid, 0);
      check("rst_m1_rdv", m1_if.readdatavalid, 0);
      check("rst_m0_rdata", m0_if.readdata, 0);
      check("rst_m1_rdata", m1_if.readdata, 0);
      check("rst_cs", mem_chipselect, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_clken", mem_clken, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("clken", mem_clken, 1);
      @(posedge clk);
      #1;

      // m0 write then read back
      do_cmd(0, 1'b0, 1'b1, 13'h0010, 4'hF, 32'hDEADBEEF, 1, n);
      check("t1_wr_wait", n, 2);
      do_cmd(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0, 1, n);
      check("t1_rd_wait", n, 2);
      drain(4);
      check("t1_rdata", m0_if.readdata, 32'hDEADBEEF);

      // m1 partial write (bytes 0 and 2) then read back; m0 stays quiet
      c0 = rdv0_cnt;
      do_cmd(1, 1'b0, 1'b1, 13'h1FFF, 4'h5, 32'h11223344, 1, n);
      do_cmd(1, 1'b1, 1'b0, 13'h1FFF, 4'hF, 32'h0, 1, n);
      drain(4);
      check("t2_rdata", m1_if.readdata, 32'hC0221F44);
      check("t2_m0_quiet", rdv0_cnt - c0, 0);

      // Simultaneous reads: last grant was m1, so m0 wins the first tie
      s = grant_log.size();
      fork
         do_cmd(0, 1'b1, 1'b0, 13'h0001, 4'hF, 32'h0, 1, n0);
         do_cmd(1, 1'b1, 1'b0, 13'h0002, 4'hF, 32'h0, 1, n1);
      join
      drain(4);
      check("t3a_first", grant_log[s], 0);
      check("t3a_second", grant_log[s+1], 1);
      // A lone m0 read leaves last_grant at m0, so the next tie goes to m1
      do_cmd(0, 1'b1, 1'b0, 13'h0001, 4'hF, 32'h0, 1, n);
      drain(4);
      s = grant_log.size();
      fork
         do_cmd(0, 1'b1, 1'b0, 13'h0001, 4'hF, 32'h0, 1, n0);
         do_cmd(1, 1'b1, 1'b0, 13'h0002, 4'hF, 32'h0, 1, n1);
      join
      drain(4);
`ifdef ONCHIP_MEM_ARB_FIXED_PRIO_EN
      check("t3b_first", grant_log[s], 0);
      check("t3b_second", grant_log[s+1], 1);
`else
      check("t3b_first", grant_log[s], 1);
      check("t3b_second", grant_log[s+1], 0);
`endif

      // Back-to-back contention, 32 commands per master
      s = grant_log.size();
      fork
         stream(0, 32);
         stream(1, 32);
      join
      drain(6);
      check("t4_count", grant_log.size() - s, 64);
`ifndef ONCHIP_MEM_ARB_FIXED_PRIO_EN
      for (int i = s + 1; i < grant_log.size(); i++)
         check("t4_alternate", grant_log[i] != grant_log[i-1], 1);
`endif

      // Reset during the RESP cycle of an m1 read drops the response
      c1 = rdv1_cnt;
      do_cmd(1, 1'b1, 1'b0, 13'h0002, 4'hF, 32'h0, 0, n);
      reset = 1'b1;
      @(negedge clk);
      check("t5_clken", mem_clken, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("t5_m0_wait", m0_if.waitrequest, 1);
      check("t5_m1_wait", m1_if.waitrequest, 1);
      check("t5_cs", mem_chipselect, 0);
      check("t5_m1_rdv", m1_if.readdatavalid, 0);
      drain(3);
      check("t5_no_rdv", rdv1_cnt - c1, 0);

      // Read+write together: write wins, no read response
      c0 = rdv0_cnt;
      do_cmd(0, 1'b1, 1'b1, 13'h0003, 4'hF, 32'hA5A5A5A5, 1, n);
      drain(4);
      check("t6_ram", ram[3], 32'hA5A5A5A5);
      check("t6_no_rdv", rdv0_cnt - c0, 0);
      do_cmd(0, 1'b1, 1'b0, 13'h0003, 4'hF, 32'h0, 1, n);
      drain(4);
      check("t6_rdata", m0_if.readdata, 32'hA5A5A5A5);

      check("sb0_empty", sb0.size(), 0);
      check("sb1_empty", sb1.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-master arbiter for the single-port 8192 x 32 on-chip RAM.
- Lets the Nios data master (m0) and a second Avalon-MM master (m1, e.g. DMA or video fetch) share one RAM port.
- Each master sees an Avalon-MM slave interface with waitrequest and readdatavalid.
- Drives the RAM's address, byteenable, chipselect, write, writedata and clken, and returns registered read data to the winning master.

Parameters:
- ADDR_W, 13, word address width; must match the RAM's widthad.
- DATA_W, 32, data width; byteenable width is the local constant BE_W = DATA_W/8.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_address  in  ADDR_W  master 0 word address
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_byteenable  in  BE_W  master 0 byte lanes
- m0_writedata  in  DATA_W  master 0 write data
- m0_waitrequest  out  1  low for exactly the accept cycle
- m0_readdata  out  DATA_W  registered read data
- m0_readdatavalid  out  1  one-cycle read-data strobe
- m1_*  same set of signals as m0_*, for master 1
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  BE_W  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  to RAM clken; equals ~reset
- mem_readdata  in  DATA_W  RAM q; valid one cycle after the address cycle

Behaviour:
- States: IDLE, ISSUE, RESP. State reg, grant reg (1 bit) and last_grant reg (1 bit).
- Reset values:
  - state = IDLE, last_grant = 1 (so m0 wins the first tie).
  - Both waitrequest = 1, both readdatavalid = 0, both readdata = 0.
  - mem_chipselect = 0, mem_write = 0.
- Reset taken in any state returns to IDLE. An in-flight read is dropped and no readdatavalid is issued for it.
- Request: req_i = mi_read | mi_write. Masters hold the command stable until they see waitrequest = 0.
- IDLE:
  - Neither request: stay in IDLE.
  - One request: grant that master.
  - Both requests: grant = ~last_grant (round-robin).
  - On a grant: latch grant, set last_grant = grant, go to ISSUE.
- ISSUE (one cycle):
  - mem_* is driven combinationally from the granted master's live signals, with mem_chipselect = 1 and mem_write = granted write.
  - The granted master's waitrequest = 0 and its command is accepted at this clock edge.
  - Write: next state IDLE.
  - Read: next state RESP.
- RESP:
  - mem_chipselect = 0.
  - mem_readdata is captured into the granted master's readdata register, and its readdatavalid register is set to 1 for the next cycle only. Next state IDLE.
- Outside ISSUE:
  - Both waitrequest = 1, mem_chipselect = 0, mem_write = 0.
  - mem_address, mem_byteenable and mem_writedata hold the last granted master's values (don't-care to the RAM).
- Latency:
  - Write: 2 cycles from request to accept.
  - Read: accept at cycle 1 after the request is seen, readdatavalid at cycle 3.
  - Sustained throughput: one write per 2 cycles, one read per 3 cycles.
- readdatavalid is a register cleared each cycle unless set from RESP. It may coincide with IDLE arbitration of a new command.
- The non-granted master's readdata holds its previous value.
- Protocol violation (read and write asserted together by one master): the write takes precedence and no readdatavalid is generated.
- Under contention a master waits at most one competing transaction (3 cycles) plus its own.

Optional Feature:
- Macro: ONCHIP_MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. m0 always wins when both masters request; last_grant is still updated but ignored, so m1 can starve while m0 keeps requesting.
- Undefined (default): round-robin as specified in Behaviour.

Test Plan:
- After reset, m0 writes 0xDEADBEEF to address 0x0010 with byteenable 0xF, then reads 0x0010:
  - m0_waitrequest is low in cycle 1 for each command.
  - m0_readdatavalid is high exactly 3 cycles after the read request, with m0_readdata = 0xDEADBEEF.
- m1 writes 0x11223344 to address 0x1FFF with byteenable 0x5, then reads 0x1FFF:
  - Bytes 0 and 2 are updated, bytes 1 and 3 are unchanged.
  - m0_readdatavalid stays 0 throughout.
- Both masters issue reads in the same cycle, to 0x0001 (m0) and 0x0002 (m1):
  - m0 is served first, then m1.
  - Next simultaneous pair: m1 first (alternation).
  - With ONCHIP_MEM_ARB_FIXED_PRIO_EN defined, m0 is first both times.
- Continuous back-to-back requests from both masters for 64 transactions:
  - Grants alternate strictly and neither master waits more than 6 cycles.
  - All read data matches a scoreboard model.
- Reset asserted in the RESP cycle of an m1 read:
  - No m1_readdatavalid pulse occurs.
  - The next cycle shows IDLE state outputs (waitrequest = 1, mem_chipselect = 0).
- m0 asserts read and write together to 0x0003 with data 0xA5A5A5A5:
  - The RAM is written with 0xA5A5A5A5.
  - No m0_readdatavalid pulse occurs.
